// File: rtl/lcd_bus_driver_if.sv
// Sequencer-to-driver handshake plus the LCD pin bundle.
// The master modport is the sequencer side; the slave modport is the bus driver.
interface lcd_bus_driver_if;
    logic       inStart;
    logic       inRS;
    logic [7:0] inDATA;
    logic       outDone;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_EN;
    logic       LCD_RW;

    modport master (
        output inStart, inRS, inDATA,
        input  outDone, LCD_DATA, LCD_RS, LCD_EN, LCD_RW
    );

    modport slave (
        input  inStart, inRS, inDATA,
        output outDone, LCD_DATA, LCD_RS, LCD_EN, LCD_RW
    );
endinterface

// File: rtl/lcd_bus_driver.sv
// HD44780 write engine: latches one RS/data byte per handshake.
// It then produces a timed LCD_EN strobe (setup / pulse / hold) before signalling done.
//
// state   | meaning
// IDLE    | waiting for inStart, bus holds last written value
// SETUP   | RS/DATA settling before EN rises
// EN_HIGH | EN strobe asserted
// HOLD    | RS/DATA held after EN falls
// DONE    | outDone high until inStart drops
module lcd_bus_driver #(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned EN_HIGH_CYC = 16,
    parameter int unsigned HOLD_CYC    = 4
) (
    input  logic             clk,
    input  logic             rst,
    lcd_bus_driver_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_EN_HIGH = 3'd2,
        S_HOLD    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] EN_LAST    = 8'(EN_HIGH_CYC - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_count;
    logic [7:0] w_count_nxt;
    logic       r_lcd_en;
    logic       w_lcd_en_nxt;
    logic       r_lcd_rs;
    logic       w_lcd_rs_nxt;
    logic [7:0] r_lcd_data;
    logic [7:0] w_lcd_data_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic       w_leave;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= 8'h00;
            r_lcd_en   <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= 8'h00;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_lcd_en   <= w_lcd_en_nxt;
            r_lcd_rs   <= w_lcd_rs_nxt;
            r_lcd_data <= w_lcd_data_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.inStart)          w_state_nxt = S_SETUP;
            S_SETUP:   if (r_count == SETUP_LAST) w_state_nxt = S_EN_HIGH;
            S_EN_HIGH: if (r_count == EN_LAST)    w_state_nxt = S_HOLD;
            S_HOLD:    if (r_count == HOLD_LAST)  w_state_nxt = S_DONE;
            S_DONE:    if (!bus.inStart)         w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    assign w_leave = (w_state_nxt != r_state);

    // Every output change coincides with a state transition, so each edge is keyed off w_leave.
    always_comb begin
        w_lcd_en_nxt   = r_lcd_en;
        w_lcd_rs_nxt   = r_lcd_rs;
        w_lcd_data_nxt = r_lcd_data;
        w_done_nxt     = r_done;
        w_count_nxt    = r_count;
        if (w_leave) begin
            w_count_nxt = 8'h00;
        end else if (r_state == S_SETUP || r_state == S_EN_HIGH || r_state == S_HOLD) begin
            w_count_nxt = r_count + 8'h01;
        end
        case (r_state)
            S_IDLE: if (w_leave) begin
                w_lcd_rs_nxt   = bus.inRS;
                w_lcd_data_nxt = bus.inDATA;
            end
            S_SETUP:   if (w_leave) w_lcd_en_nxt = 1'b1;
            S_EN_HIGH: if (w_leave) w_lcd_en_nxt = 1'b0;
            S_HOLD:    if (w_leave) w_done_nxt   = 1'b1;
            S_DONE:    if (w_leave) w_done_nxt   = 1'b0;
            default: begin
                w_lcd_en_nxt = 1'b0;
                w_done_nxt   = 1'b0;
            end
        endcase
    end

    assign bus.LCD_EN   = r_lcd_en;
    assign bus.LCD_RS   = r_lcd_rs;
    assign bus.LCD_DATA = r_lcd_data;
    assign bus.outDone  = r_done;
    assign bus.LCD_RW   = 1'b0;

endmodule
